// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester, memory and consumer signals of fifo_wr_arbiter.
// req_last exists only when ARB_BURST_LOCK_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req, gnt;
  logic [NREQ*DATASIZE-1:0] req_data;
`ifdef ARB_BURST_LOCK_EN
  logic [NREQ-1:0] req_last;
`endif
  logic winc, wfull, rd_valid, rd_ready, rempty;
  logic [ADDRSIZE-1:0] waddr, raddr;
  logic [DATASIZE-1:0] wdata;
  logic [ADDRSIZE:0] count;
  modport slave(
    input req, req_data, rd_ready,
`ifdef ARB_BURST_LOCK_EN
    input req_last,
`endif
    output gnt, winc, waddr, wdata, wfull, raddr, rd_valid, rempty, count
  );
  modport master(
    output req, req_data, rd_ready,
`ifdef ARB_BURST_LOCK_EN
    output req_last,
`endif
    input gnt, winc, waddr, wdata, wfull, raddr, rd_valid, rempty, count
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter plus pointer/count control for a single-write-port FIFO memory.
// Define ARB_BURST_LOCK_EN to hold the grant on one requester until its req_last beat.
module fifo_wr_arbiter #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int NREQ = 4
) (
  input logic wclk,
  input logic wrst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam logic [ADDRSIZE:0] ONE = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
  logic [ADDRSIZE:0] wptr, rptr, count, count_nxt;
  logic [PW-1:0] prio, prio_nxt, rr, sel;
  logic any, lock, acc, pop, last;
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction
  // scan downwards so the requester closest to prio is written last and wins
  always_comb begin
    rr = prio;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req[wrap(int'(prio) + k)]) begin
        rr = wrap(int'(prio) + k);
        any = 1'b1;
      end
  end
`ifdef ARB_BURST_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] owner, owner_nxt;
  assign lock = state == LOCKED;
  assign sel = lock ? owner : rr;
  assign last = bus.req_last[sel];
  always_comb begin
    state_nxt = acc ? (last ? IDLE : LOCKED) : state;
    owner_nxt = acc ? sel : owner;
  end
  always_ff @(posedge wclk)
    if (wrst) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
`else
  assign lock = 1'b0;
  assign sel = rr;
  assign last = 1'b1;
`endif
  assign bus.gnt = (wrst || !(any || lock)) ? '0 : NREQ'(1) << sel;
  assign acc = |(bus.gnt & bus.req) & !bus.wfull;
  assign pop = bus.rd_valid & bus.rd_ready & !wrst;
  assign bus.winc = acc;
  assign bus.waddr = wptr[ADDRSIZE-1:0];
  assign bus.raddr = rptr[ADDRSIZE-1:0];
  assign bus.wdata = bus.req_data[int'(sel)*DATASIZE +: DATASIZE];
  assign bus.rd_valid = !bus.rempty;
  assign bus.count = count;
  assign prio_nxt = (acc && last) ? wrap(int'(sel) + 1) : prio;
  assign count_nxt = (acc && !pop) ? count + ONE : (pop && !acc) ? count - ONE : count;
  // full/empty come from the occupancy count, so pointer wrap never aliases them
  always_ff @(posedge wclk)
    if (wrst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      prio <= '0;
      bus.wfull <= 1'b0;
      bus.rempty <= 1'b1;
    end else begin
      wptr <= acc ? wptr + ONE : wptr;
      rptr <= pop ? rptr + ONE : rptr;
      count <= count_nxt;
      prio <= prio_nxt;
      bus.wfull <= count_nxt == DEPTH;
      bus.rempty <= count_nxt == '0;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Single-clock write-side arbiter and pointer controller for the FIFO memory in the FIFO subsystem. It shares the memory's single write port between NREQ requesters using round-robin arbitration, and owns the write and read pointers and the occupancy count. It drives `winc`, `waddr`, `wdata`, `raddr` and `wfull` into the memory and presents a valid/ready read interface to one consumer.

## Interface
- `DATASIZE`, 8, word width; must match the memory.
- `ADDRSIZE`, 4, address bits; depth = 2^ADDRSIZE.
- `NREQ`, 4, number of write requesters, 2..8.
- `wclk`  in  1  clock for all logic and the memory write port.
- `wrst`  in  1  reset: synchronous, active-high.
- `req`  in  NREQ  per-requester write request; held high until accepted.
- `req_data`  in  NREQ*DATASIZE  per-requester write data; slice i belongs to requester i.
- `req_last`  in  NREQ  last beat of a burst; exists only with ARB_BURST_LOCK_EN.
- `gnt`  out  NREQ  one-hot grant; a beat is accepted when `gnt[i]` is high and `wfull` is low.
- `winc`  out  1  memory write enable.
- `waddr`  out  ADDRSIZE  memory write address.
- `wdata`  out  DATASIZE  memory write data: the granted requester's slice.
- `wfull`  out  1  FIFO full; registered.
- `raddr`  out  ADDRSIZE  memory read address; the memory returns `rdata` combinationally.
- `rd_valid`  out  1  head word available; equals `!rempty`.
- `rd_ready`  in  1  consumer pops the head word when it is high together with `rd_valid`.
- `rempty`  out  1  FIFO empty; registered.
- `count`  out  ADDRSIZE+1  occupancy, 0..2^ADDRSIZE.

## Operation
- Arbitration: combinational round-robin from the priority pointer `prio` (0..NREQ-1).
  - The first requester at or after `prio` with `req` high gets `gnt`, wrapping modulo NREQ.
  - `gnt` is all-zero when no `req` bit is high.
- `gnt` is driven while `wfull` is high, but no beat is accepted.
- Accept condition: `acc = |(gnt & req) & !wfull`. Definitions:
  - `winc = acc`
  - `wdata = req_data[g]` for granted index g
  - `waddr = wptr[ADDRSIZE-1:0]`
- On accept: `wptr` += 1 (ADDRSIZE+1 bits, wraps naturally), and `prio` ← (g+1) mod NREQ.
- Pop condition: `pop = rd_valid & rd_ready`. On pop, `rptr` += 1. `raddr = rptr[ADDRSIZE-1:0]`.
- Count update, next state:
  - acc only: count+1
  - pop only: count−1
  - acc and pop: unchanged
- Flags are registered from the next-state count:
  - `wfull` = (next count == 2^ADDRSIZE)
  - `rempty` = (next count == 0)
- Boundaries:
  - Full: writes are blocked even when a pop occurs in the same cycle. `wfull` falls one cycle after the pop.
  - Empty: no read bypass. A word written in cycle N is visible on `rd_valid` in cycle N+1.
  - Pointer wrap: the address wraps at 2^ADDRSIZE. Full and empty are decided only by `count`, never by pointer compare.
  - Requester drops `req` without acceptance: no state change, and `prio` does not advance.

## Timing
- Reset (synchronous, `wrst` high at a `wclk` edge) sets:
  - `wptr` = 0, `rptr` = 0, `count` = 0, `prio` = 0
  - `rempty` = 1, `wfull` = 0, `rd_valid` = 0
  - burst FSM = IDLE
- With `wrst` high, `gnt`, `winc` and `pop` are forced to 0. A beat that is mid-burst at reset is discarded.
- Grant-to-write latency is zero: the memory samples `wdata` at the same edge that updates `wptr`.
- Write-to-read visibility is 1 cycle. Sustained throughput is 1 write and 1 read per cycle.

## Configuration
- `ARB_BURST_LOCK_EN` defined:
  - Adds the `req_last` port and a 2-state FSM with states IDLE and LOCKED.
  - IDLE → LOCKED on an accepted beat with `req_last[g]` low. The FSM stores g as `owner`.
  - In LOCKED, `gnt` = onehot(owner) regardless of other requests.
  - LOCKED → IDLE on an accepted beat with `req_last[owner]` high; `prio` then advances to owner+1.
  - `prio` does not advance on non-last beats.
- `ARB_BURST_LOCK_EN` undefined:
  - No `req_last` port and no FSM.
  - Grant rotates after every accepted beat.

## Test plan
- Reset then idle: `wrst` for 2 cycles → `rempty`=1, `wfull`=0, `count`=0, `gnt`=0, `winc`=0.
- Fairness: NREQ=4, all `req` high, `rd_ready` high → grant order 0,1,2,3,0. `rd_valid` data sequence matches the requester slices in that order.
- Fill to full: only `req[2]` high with data 0x10..0x1F, `rd_ready` low → `count` reaches 16 and `wfull`=1. The 17th beat is not accepted (`winc`=0).
- Full with simultaneous pop: full, `req` high, `rd_ready` high → that cycle `winc`=0 and the pop yields 0x10. Next cycle `wfull`=0 and the write is accepted.
- Pointer wrap: 40 write/read pairs at steady occupancy 3 → data order preserved across `waddr` 15→0.
- Burst lock (macro on): `req[0]` burst of 3 beats with `req_last` on beat 3, `req[1]` high throughout → `gnt` = 0,0,0,1. Mid-burst `wrst` returns the FSM to IDLE and `prio` to 0.
